controlador_contador: RTL and testbench
=======================================

// Module: controlador_contador
// PURPOSE
//   Sequencing controller for the team's synchronous up-counter datapath.
//   Accepts start/stop/pause commands and a programmable terminal value.
//   Runs the counter single-shot or continuous.
//   Reports busy, a terminal-count pulse and a done flag to the surrounding control logic.
//   Sits between the system control FSM and the counter core it instantiates.
// PARAMETERS
//   WIDTH    4  counter/limit width in bits
//   PRESC_W  8  prescaler divider width (used only with CTRL_PRESCALER_EN)
// PORTS
//   clk         in   1        system clock, rising edge
//   rst         in   1        asynchronous reset, active-low (0 = reset)
//   start       in   1        begin a run; sampled in IDLE/DONE only
//   stop        in   1        abort run, return to IDLE
//   pause       in   1        level; hold count while high (RUN/PAUSE only)
//   continuous  in   1        mode, latched on start: 1 = wrap, 0 = single-shot
//   limit       in   WIDTH    terminal value, latched on start
//   presc_div   in   PRESC_W  tick divider; ignored without CTRL_PRESCALER_EN
//   count       out  WIDTH    current counter value
//   state       out  2        IDLE=0 RUN=1 PAUSE=2 DONE=3
//   busy        out  1        1 in RUN or PAUSE
//   tc          out  1        one-cycle registered terminal-count pulse
//   done        out  1        level, 1 in DONE
// BEHAVIOUR
//   - rst=0 (async, no clock needed): state=IDLE, count=0, busy=0, tc=0, done=0.
//     Also clears limit_q, mode_q and the prescaler.
//     Applies immediately, including mid-run.
//   - Command priority each edge: stop > pause > start > tick.
//   - IDLE: start=1 latches limit_q/mode_q, sets count=0, moves to RUN.
//     stop and pause are no-ops in IDLE.
//   - RUN, tick with count!=limit_q: count+1.
//   - RUN, tick with count==limit_q:
//       tc=1 for the next cycle only.
//       mode_q=1: count=0, stay in RUN.
//       mode_q=0: count holds limit_q, go to DONE, done=1.
//   - Latency: start sampled at edge 0 -> count=n after edge n (n<=L).
//     tc/done appear after edge L+1. Continuous period = L+1 ticks.
//   - limit_q=0: every tick is terminal; tc pulses each tick, count stays 0.
//   - pause=1 in RUN -> PAUSE: count and prescaler held, no tc.
//     pause=0 -> RUN on the next edge; the first increment follows one edge later.
//   - stop in RUN/PAUSE/DONE -> IDLE, count=0, tc suppressed that edge.
//   - DONE: count and done held. start restarts exactly as from IDLE (done clears).
//   - start is ignored in RUN/PAUSE.
//     limit/continuous changes are ignored after latching.
//   - No overflow: count never exceeds limit_q. All arithmetic is modulo 2^WIDTH, unsigned.
// CONFIGURATION
//   CTRL_PRESCALER_EN defined:
//     tick=1 when the prescaler reaches presc_div; the prescaler then reloads 0.
//     presc_div=0 gives a tick every clk.
//     Prescaler cleared on start/stop, held in PAUSE.
//   Undefined: tick=1 every clk; no prescaler register; presc_div unconnected.
// STRUCTURE
//   contador_pkg: state enum (S_IDLE/S_RUN/S_PAUSE/S_DONE), state width, default WIDTH.
//   Sub-module contador_nucleo: WIDTH-bit register with clr/en/hold and async active-low rst.
//   FSM, latches, prescaler and tc/done flops stay in controlador_contador.
// TESTING
//   1. Run limit=9 continuous, pull rst=0 at count=5 between edges
//      -> all outputs 0, state=IDLE without a clock edge.
//   2. start, limit=3, continuous=0 -> count 1,2,3 on edges 1-3.
//      tc=1 only after edge 4; then done=1, count=3, busy=0.
//   3. start, limit=4, continuous=1 -> count 0..4 repeating.
//      tc every 5 cycles; busy stays 1 for 20 cycles.
//   4. limit=7, pause high at count=2 for 3 cycles -> count stays 2, state=PAUSE.
//      Resumes 3 one edge after release. stop+pause same edge -> IDLE, count=0, no tc.
//   5. limit=0 single-shot -> tc and done after edge 1, count=0.
//      start again in DONE -> restarts; start during RUN ignored.
//   6. CTRL_PRESCALER_EN, presc_div=2, limit=1 continuous
//      -> count changes every 3 clk, tc every 6 clk.
//      Without the macro the same stimulus gives tc every 2 clk.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared types for the counter sequencing controller: FSM state encoding and default widths.
package contador_pkg;
  localparam int STATE_W = 2;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/contador_nucleo.sv
// Counter core: WIDTH-bit register with synchronous clear, hold and increment enable.
import contador_pkg::*;

module contador_nucleo #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  // Priority clr > hold > en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (!hold && en)
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/controlador_contador.sv
// Start/stop/pause sequencer around contador_nucleo, single-shot or continuous.
// Optional tick prescaler enabled by defining CTRL_PRESCALER_EN.
import contador_pkg::*;

module controlador_contador #(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               continuous,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc_div,
  output logic [WIDTH-1:0]   count,
  output logic [1:0]         state,
  output logic               busy,
  output logic               tc,
  output logic               done
);

  // state   | meaning
  // S_IDLE  | waiting for start, count cleared
  // S_RUN   | counting on each tick
  // S_PAUSE | count and prescaler held while pause is high
  // S_DONE  | single-shot finished, count holds limit_q

  state_t           state_q;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic             tick;
  logic             terminal;
  logic             stop_act;
  logic             pause_act;
  logic             start_act;
  logic             tick_act;
  logic             clr;
  logic             en;

`ifdef CTRL_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q;

  assign tick = (presc_q == presc_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      presc_q <= '0;
    else if (start_act || stop_act)
      presc_q <= '0;
    else if (state_q == S_RUN && !pause_act)
      presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
  end
`else
  logic presc_unused;

  assign tick = 1'b1;
  assign presc_unused = ^presc_div;
`endif

  assign terminal  = (count == limit_q);
  assign stop_act  = stop && (state_q != S_IDLE);
  assign pause_act = pause && !stop_act && (state_q == S_RUN || state_q == S_PAUSE);
  assign start_act = start && !stop_act && (state_q == S_IDLE || state_q == S_DONE);
  assign tick_act  = tick && !stop_act && !pause_act && (state_q == S_RUN);

  // Continuous wrap goes through clr so the core never counts past limit_q.
  assign clr = stop_act || start_act || (tick_act && terminal && mode_q);
  assign en  = tick_act && !terminal;

  contador_nucleo #(.WIDTH(WIDTH)) u_nucleo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (en),
    .hold  (pause_act),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      limit_q <= '0;
      mode_q  <= 1'b0;
      busy    <= 1'b0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (stop_act) begin
        state_q <= S_IDLE;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              limit_q <= limit;
              mode_q  <= continuous;
              state_q <= S_RUN;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end
          S_RUN: begin
            if (pause) begin
              state_q <= S_PAUSE;
            end else if (tick && terminal) begin
              tc <= 1'b1;
              if (!mode_q) begin
                state_q <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          S_PAUSE: begin
            if (!pause)
              state_q <= S_RUN;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_controlador_contador.sv
// Directed bench for controlador_contador; expectations track CTRL_PRESCALER_EN when defined.
`timescale 1ns/1ps
module tb_controlador_contador;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] limit = '0;
  logic [7:0] presc_div = '0;
  logic [3:0] count;
  logic [1:0] state;
  logic       busy;
  logic       tc;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  controlador_contador #(.WIDTH(4), .PRESC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .continuous (continuous),
    .limit      (limit),
    .presc_div  (presc_div),
    .count      (count),
    .state      (state),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({count, state, busy, tc, done} !== 9'd0) begin
      n_err++; $display("FAIL reset_init: got cnt=%0d st=%0d b=%0d tc=%0d d=%0d, want all 0", count, state, busy, tc, done);
    end
    rst = 1'b1;
    step();
    start = 1'b1; limit = 4'd9; continuous = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    n_cmp++; if (count !== 4'd5) begin
      n_err++; $display("FAIL reset_precount: got %0d want 5", count);
    end
    #3 rst = 1'b0;
    #1;
    n_cmp++; if ({count, state, busy, tc, done} !== 9'd0) begin
      n_err++; $display("FAIL reset_async: got cnt=%0d st=%0d b=%0d tc=%0d d=%0d, want all 0", count, state, busy, tc, done);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_single_shot();
    start = 1'b1; limit = 4'd3; continuous = 1'b0;
    step();
    start = 1'b0;
    n_cmp++; if (state !== 2'd1 || busy !== 1'b1 || count !== 4'd0) begin
      n_err++; $display("FAIL ss_start: got st=%0d b=%0d cnt=%0d want 1/1/0", state, busy, count);
    end
    for (int n = 1; n <= 3; n++) begin
      step();
      n_cmp++; if (count !== 4'(n) || tc !== 1'b0 || done !== 1'b0) begin
        n_err++; $display("FAIL ss_count%0d: got cnt=%0d tc=%0d d=%0d want %0d/0/0", n, count, tc, done, n);
      end
    end
    step();
    n_cmp++; if (tc !== 1'b1 || done !== 1'b1 || count !== 4'd3 || busy !== 1'b0 || state !== 2'd3) begin
      n_err++; $display("FAIL ss_term: got tc=%0d d=%0d cnt=%0d b=%0d st=%0d want 1/1/3/0/3", tc, done, count, busy, state);
    end
    step();
    n_cmp++; if (tc !== 1'b0 || done !== 1'b1 || count !== 4'd3) begin
      n_err++; $display("FAIL ss_hold: got tc=%0d d=%0d cnt=%0d want 0/1/3", tc, done, count);
    end
  endtask

  task automatic test_continuous();
    start = 1'b1; limit = 4'd4; continuous = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (count !== 4'd0 || done !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL cont_start: got cnt=%0d d=%0d b=%0d want 0/0/1", count, done, busy);
    end
    for (int n = 1; n <= 19; n++) begin
      step();
      n_cmp++; if (count !== 4'(n % 5) || tc !== (n % 5 == 0) || busy !== 1'b1) begin
        n_err++; $display("FAIL cont_edge%0d: got cnt=%0d tc=%0d b=%0d want %0d/%0d/1", n, count, tc, busy, n % 5, n % 5 == 0);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if (state !== 2'd0 || count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL cont_stop_on_tc: got st=%0d cnt=%0d tc=%0d b=%0d want 0/0/0/0", state, count, tc, busy);
    end
  endtask

  task automatic test_pause();
    start = 1'b1; limit = 4'd7; continuous = 1'b0;
    step();
    start = 1'b0; limit = 4'd1; continuous = 1'b1;
    repeat (2) step();
    n_cmp++; if (count !== 4'd2) begin
      n_err++; $display("FAIL pause_pre: got %0d want 2", count);
    end
    pause = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      n_cmp++; if (count !== 4'd2 || state !== 2'd2 || tc !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL pause_hold%0d: got cnt=%0d st=%0d tc=%0d b=%0d want 2/2/0/1", n, count, state, tc, busy);
      end
    end
    pause = 1'b0;
    step();
    n_cmp++; if (count !== 4'd2 || state !== 2'd1) begin
      n_err++; $display("FAIL pause_release: got cnt=%0d st=%0d want 2/1", count, state);
    end
    step();
    n_cmp++; if (count !== 4'd3) begin
      n_err++; $display("FAIL pause_resume: got %0d want 3", count);
    end
    stop = 1'b1; pause = 1'b1;
    step();
    stop = 1'b0; pause = 1'b0;
    n_cmp++; if (state !== 2'd0 || count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL pause_stop: got st=%0d cnt=%0d tc=%0d b=%0d want 0/0/0/0", state, count, tc, busy);
    end
  endtask

  task automatic test_limit_zero();
    start = 1'b1; limit = 4'd0; continuous = 1'b0;
    step();
    start = 1'b0;
    step();
    n_cmp++; if (tc !== 1'b1 || done !== 1'b1 || count !== 4'd0 || state !== 2'd3) begin
      n_err++; $display("FAIL lim0_term: got tc=%0d d=%0d cnt=%0d st=%0d want 1/1/0/3", tc, done, count, state);
    end
    start = 1'b1; limit = 4'd2;
    step();
    n_cmp++; if (state !== 2'd1 || done !== 1'b0 || count !== 4'd0) begin
      n_err++; $display("FAIL restart_done: got st=%0d d=%0d cnt=%0d want 1/0/0", state, done, count);
    end
    for (int n = 1; n <= 2; n++) begin
      step();
      n_cmp++; if (count !== 4'(n) || state !== 2'd1) begin
        n_err++; $display("FAIL start_in_run%0d: got cnt=%0d st=%0d want %0d/1", n, count, state, n);
      end
    end
    start = 1'b0;
    step();
    n_cmp++; if (tc !== 1'b1 || done !== 1'b1 || count !== 4'd2) begin
      n_err++; $display("FAIL restart_term: got tc=%0d d=%0d cnt=%0d want 1/1/2", tc, done, count);
    end
  endtask

  task automatic test_prescaler();
    logic [3:0] exp_cnt;
    logic       exp_tc;
    int         k;
    presc_div = 8'd2;
    start = 1'b1; limit = 4'd1; continuous = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
`ifdef CTRL_PRESCALER_EN
      k = n / 3;
      exp_cnt = 4'(k % 2);
      exp_tc = (n % 3 == 0) && (k % 2 == 0);
`else
      k = n;
      exp_cnt = 4'(n % 2);
      exp_tc = (n % 2 == 0);
`endif
      n_cmp++; if (count !== exp_cnt || tc !== exp_tc) begin
        n_err++; $display("FAIL presc_edge%0d: got cnt=%0d tc=%0d want %0d/%0d (k=%0d)", n, count, tc, exp_cnt, exp_tc, k);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    presc_div = 8'd0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_continuous();
    test_pause();
    test_limit_zero();
    test_prescaler();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
